// File: rtl/fireball_pkg.sv
// Shared constants and state encoding for the fireball launcher.
// Screen, keyboard and magazine parameters used by the launcher and its bench.
package fireball_pkg;

  localparam logic [7:0] FIRE_KEY        = 8'h2C;
  localparam logic [7:0] RELOAD_KEY      = 8'h15;
  localparam logic [9:0] X_LIMIT         = 10'd639;
  localparam logic [3:0] AMMO_MAX        = 4'd5;
  localparam logic [3:0] COOLDOWN_FRAMES = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    FLYING   = 3'd2,
    RETIRE   = 3'd3,
    COOLDOWN = 3'd4
  } launch_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Synchronises an asynchronous frame tick and emits a one-cycle registered
// pulse two cycles after each rising edge; reusable by any sprite block.
module frame_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic edge_o
);

  logic d1_q;
  logic d2_q;
  logic edge_q;

  // Two-flop delay line plus a registered rising-edge detector
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      d1_q   <= level_i;
      d2_q   <= d1_q;
      edge_q <= d1_q & ~d2_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/fireball_launcher.sv
// Fireball launch controller: takes key presses, sequences one shot at a time
// through launch, flight, retire and cooldown, and tracks ammo and hits.
module fireball_launcher
  import fireball_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [19:0] sprite_xpos,
  input  logic [9:0]  sprite_W,
  input  logic        target_hit,
  output logic        spr_on,
  output logic        inc,
  output logic [3:0]  ammo,
  output logic [7:0]  hits,
  output logic        busy
);

  launch_state_t state_q, state_d;
  logic [3:0]    ammo_q, ammo_d;
  logic [7:0]    hits_q, hits_d;
  logic [3:0]    cd_q, cd_d;
  logic [7:0]    key_prev_q;
  logic          spr_on_q, spr_on_d;
  logic          inc_q, inc_d;
  logic          busy_q, busy_d;

  logic          frame_edge_s;
  logic          fire_press_s;
  logic          reload_press_s;
  logic [10:0]   right_s;
  logic          at_edge_s;
  logic          unused_xpos_s;

  frame_edge_sync u_frame_edge_sync (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .level_i (frame_clk),
    .edge_o  (frame_edge_s)
  );

  assign fire_press_s   = (keycode == FIRE_KEY)   && (key_prev_q != FIRE_KEY);
  assign reload_press_s = (keycode == RELOAD_KEY) && (key_prev_q != RELOAD_KEY);

  // 11-bit sum so a wide sprite near the edge cannot wrap past the limit
  assign right_s       = {1'b0, sprite_xpos[9:0]} + {1'b0, sprite_W};
  assign at_edge_s     = right_s >= {1'b0, X_LIMIT};
  assign unused_xpos_s = ^sprite_xpos[19:10];

  // Next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    hits_d  = hits_q;
    cd_d    = cd_q;
    case (state_q)
      IDLE: begin
        if (reload_press_s) begin
          ammo_d = AMMO_MAX;
        end else if (fire_press_s && (ammo_q != 4'd0)) begin
          ammo_d  = ammo_q - 4'd1;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = FLYING;
      end
      FLYING: begin
        if (target_hit) begin
          hits_d  = sat_inc8(hits_q);
          state_d = RETIRE;
        end else if (at_edge_s) begin
          state_d = RETIRE;
        end else begin
          state_d = FLYING;
        end
      end
      RETIRE: begin
        cd_d    = COOLDOWN_FRAMES;
        state_d = COOLDOWN;
      end
      COOLDOWN: begin
        if (frame_edge_s) begin
          if (cd_q <= 4'd1) begin
            cd_d    = 4'd0;
            state_d = IDLE;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end else begin
          cd_d = cd_q;
        end
      end
      default: begin
        state_d = IDLE;
        cd_d    = 4'd0;
      end
    endcase

    spr_on_d = (state_d == FLYING);
    inc_d    = (state_d == LAUNCH) || (state_d == RETIRE);
    busy_d   = (state_d != IDLE);
  end

  // State, counters, key history and registered outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ammo_q     <= AMMO_MAX;
      hits_q     <= 8'd0;
      cd_q       <= 4'd0;
      key_prev_q <= 8'h00;
      spr_on_q   <= 1'b0;
      inc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ammo_q     <= ammo_d;
      hits_q     <= hits_d;
      cd_q       <= cd_d;
      key_prev_q <= keycode;
      spr_on_q   <= spr_on_d;
      inc_q      <= inc_d;
      busy_q     <= busy_d;
    end
  end

  assign spr_on = spr_on_q;
  assign inc    = inc_q;
  assign ammo   = ammo_q;
  assign hits   = hits_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fireball_launcher.sv
// Self-checking bench for fireball_launcher: scenario tasks with a small
// ammo/hits model and a queue of expected ammo values checked at each launch.
module tb_fireball_launcher;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [19:0] sprite_xpos = 20'd0;
  logic [9:0]  sprite_W = 10'd10;
  logic        target_hit = 1'b0;
  logic        spr_on;
  logic        inc;
  logic [3:0]  ammo;
  logic [7:0]  hits;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  exp_ammo = 4'd5;
  logic [7:0]  exp_hits = 8'd0;
  logic [3:0]  sb_ammo[$];

  fireball_launcher dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .sprite_xpos (sprite_xpos),
    .sprite_W    (sprite_W),
    .target_hit  (target_hit),
    .spr_on      (spr_on),
    .inc         (inc),
    .ammo        (ammo),
    .hits        (hits),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    tick();
    tick();
    frame_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_inc(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (inc === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Press fire, check launch against the scoreboard, retire via hit or edge, cool down
  task automatic fire_shot(input bit use_hit);
    bit         found;
    logic [3:0] want;
    if (exp_ammo == 4'd0) begin
      keycode = 8'h15;
      tick();
      keycode = 8'h00;
      tick();
      exp_ammo = 4'd5;
      checks++;
      if (ammo !== exp_ammo) begin
        errors++;
        $display("FAIL shot_reload: ammo got %0d expected %0d", ammo, exp_ammo);
      end
    end
    keycode = 8'h00;
    tick();
    keycode  = 8'h2C;
    exp_ammo = exp_ammo - 4'd1;
    sb_ammo.push_back(exp_ammo);
    wait_inc(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL shot_launch: inc got 0 expected 1 within 20 cycles");
      sb_ammo.delete();
    end else begin
      want = sb_ammo.pop_front();
      checks++;
      if (ammo !== want || spr_on !== 1'b0) begin
        errors++;
        $display("FAIL shot_ammo: ammo/spr_on got %0d/%0b expected %0d/0", ammo, spr_on, want);
      end
    end
    tick();
    keycode = 8'h00;
    checks++;
    if (spr_on !== 1'b1 || inc !== 1'b0) begin
      errors++;
      $display("FAIL shot_flying: spr_on/inc got %0b/%0b expected 1/0", spr_on, inc);
    end
    if (use_hit) target_hit = 1'b1;
    else sprite_xpos = 20'd630;
    tick();
    if (use_hit && exp_hits != 8'hFF) exp_hits = exp_hits + 8'd1;
    checks++;
    if (inc !== 1'b1 || spr_on !== 1'b0 || hits !== exp_hits) begin
      errors++;
      $display("FAIL shot_retire: inc/spr_on/hits got %0b/%0b/%0d expected 1/0/%0d",
               inc, spr_on, hits, exp_hits);
    end
    target_hit  = 1'b0;
    sprite_xpos = 20'd0;
    for (int i = 0; i < 8; i++) frame_pulse();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL shot_cooldown: busy got %0b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (spr_on !== 1'b0 || inc !== 1'b0 || ammo !== 4'd5 || hits !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: spr_on/inc/ammo/hits/busy got %0b/%0b/%0d/%0d/%0b expected 0/0/5/0/0",
               spr_on, inc, ammo, hits, busy);
    end
    Reset_n = 1'b1;
    tick();
    exp_ammo = 4'd5;
    exp_hits = 8'd0;
  endtask

  task automatic test_fire_held();
    bit         found;
    logic [3:0] want;
    int         extra;
    keycode  = 8'h2C;
    exp_ammo = exp_ammo - 4'd1;
    sb_ammo.push_back(exp_ammo);
    wait_inc(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fire_launch: inc got 0 expected 1 within 20 cycles");
      sb_ammo.delete();
    end else begin
      want = sb_ammo.pop_front();
      checks++;
      if (ammo !== want || spr_on !== 1'b0) begin
        errors++;
        $display("FAIL fire_ammo: ammo/spr_on got %0d/%0b expected %0d/0", ammo, spr_on, want);
      end
    end
    tick();
    checks++;
    if (spr_on !== 1'b1 || inc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fire_flying: spr_on/inc/busy got %0b/%0b/%0b expected 1/0/1", spr_on, inc, busy);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inc === 1'b1) extra++;
    end
    keycode = 8'h00;
    checks++;
    if (extra != 0 || ammo !== exp_ammo) begin
      errors++;
      $display("FAIL fire_held: extra inc/ammo got %0d/%0d expected 0/%0d", extra, ammo, exp_ammo);
    end
    // reload while flying must be ignored
    tick();
    keycode = 8'h15;
    tick();
    keycode = 8'h00;
    tick();
    checks++;
    if (ammo !== exp_ammo || spr_on !== 1'b1) begin
      errors++;
      $display("FAIL reload_in_flight: ammo/spr_on got %0d/%0b expected %0d/1", ammo, spr_on, exp_ammo);
    end
  endtask

  task automatic test_edge_retire();
    int bad;
    bad = 0;
    for (int x = 600; x < 630; x += 5) begin
      sprite_xpos = 20'(x);
      tick();
      if (inc !== 1'b0 || spr_on !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL edge_ramp: early retire cycles got %0d expected 0", bad);
    end
    sprite_xpos = 20'd630;
    tick();
    checks++;
    if (inc !== 1'b1 || spr_on !== 1'b0 || hits !== exp_hits) begin
      errors++;
      $display("FAIL edge_retire: inc/spr_on/hits got %0b/%0b/%0d expected 1/0/%0d",
               inc, spr_on, hits, exp_hits);
    end
    sprite_xpos = 20'd0;
    tick();
    checks++;
    if (inc !== 1'b0 || spr_on !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL edge_single: inc/spr_on/busy got %0b/%0b/%0b expected 0/0/1", inc, spr_on, busy);
    end
    for (int i = 0; i < 7; i++) frame_pulse();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cooldown_7: busy got %0b expected 1", busy);
    end
    frame_pulse();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_8: busy got %0b expected 0", busy);
    end
  endtask

  task automatic test_hit_and_edge();
    bit         found;
    logic [3:0] want;
    keycode = 8'h2C;
    exp_ammo = exp_ammo - 4'd1;
    sb_ammo.push_back(exp_ammo);
    wait_inc(found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL both_launch: inc got 0 expected 1 within 20 cycles");
      sb_ammo.delete();
    end else begin
      want = sb_ammo.pop_front();
      checks++;
      if (ammo !== want) begin
        errors++;
        $display("FAIL both_ammo: ammo got %0d expected %0d", ammo, want);
      end
    end
    tick();
    keycode     = 8'h00;
    target_hit  = 1'b1;
    sprite_xpos = 20'd630;
    tick();
    exp_hits = exp_hits + 8'd1;
    checks++;
    if (inc !== 1'b1 || hits !== exp_hits) begin
      errors++;
      $display("FAIL both_retire: inc/hits got %0b/%0d expected 1/%0d", inc, hits, exp_hits);
    end
    target_hit  = 1'b0;
    sprite_xpos = 20'd0;
    tick();
    checks++;
    if (inc !== 1'b0 || hits !== exp_hits) begin
      errors++;
      $display("FAIL both_single: inc/hits got %0b/%0d expected 0/%0d", inc, hits, exp_hits);
    end
    for (int i = 0; i < 8; i++) frame_pulse();
  endtask

  task automatic test_ammo_empty();
    int seen;
    while (exp_ammo != 4'd0) fire_shot(1'b0);
    checks++;
    if (ammo !== 4'd0) begin
      errors++;
      $display("FAIL ammo_zero: ammo got %0d expected 0", ammo);
    end
    keycode = 8'h2C;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inc === 1'b1 || busy === 1'b1) seen++;
    end
    keycode = 8'h00;
    checks++;
    if (seen != 0 || ammo !== 4'd0) begin
      errors++;
      $display("FAIL empty_fire: active cycles/ammo got %0d/%0d expected 0/0", seen, ammo);
    end
    tick();
    keycode = 8'h15;
    tick();
    keycode  = 8'h00;
    exp_ammo = 4'd5;
    checks++;
    if (ammo !== exp_ammo || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload: ammo/busy got %0d/%0b expected 5/0", ammo, busy);
    end
  endtask

  task automatic test_hit_saturate();
    while (exp_hits != 8'hFF) fire_shot(1'b1);
    checks++;
    if (hits !== 8'hFF) begin
      errors++;
      $display("FAIL hits_255: hits got %0d expected 255", hits);
    end
    fire_shot(1'b1);
    checks++;
    if (hits !== 8'hFF) begin
      errors++;
      $display("FAIL hits_saturate: hits got %0d expected 255", hits);
    end
  endtask

  task automatic test_reset_midflight();
    bit found;
    if (exp_ammo == 4'd0) begin
      keycode = 8'h15;
      tick();
      keycode  = 8'h00;
      tick();
      exp_ammo = 4'd5;
    end
    keycode = 8'h2C;
    wait_inc(found);
    tick();
    keycode = 8'h00;
    tick();
    checks++;
    if (!found || spr_on !== 1'b1) begin
      errors++;
      $display("FAIL midflight_setup: found/spr_on got %0b/%0b expected 1/1", found, spr_on);
    end
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    checks++;
    if (spr_on !== 1'b0 || inc !== 1'b0 || busy !== 1'b0 || ammo !== 4'd5 || hits !== 8'd0) begin
      errors++;
      $display("FAIL midflight_reset: spr_on/inc/busy/ammo/hits got %0b/%0b/%0b/%0d/%0d expected 0/0/0/5/0",
               spr_on, inc, busy, ammo, hits);
    end
    tick();
    checks++;
    if (inc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: inc/busy got %0b/%0b expected 0/0", inc, busy);
    end
    exp_ammo = 4'd5;
    exp_hits = 8'd0;
  endtask

  initial begin
    test_reset();
    test_fire_held();
    test_edge_retire();
    test_hit_and_edge();
    test_ammo_empty();
    test_hit_saturate();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
